// File: rtl/apb_regfile.sv
// apb_regfile: APB3 slave with RW registers, read-only input words, an ID word,
// configurable wait states, PSLVERR on unmapped/non-writable addresses and write strobes.
module apb_regfile #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int NREGS = 8,
  parameter int NIN = 1,
  parameter int WAIT = 0,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter logic [DATA_W-1:0] ID_VALUE = 8'hA5
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    PSEL,
  input  logic [ADDR_W-1:0]       PADDR,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [DATA_W-1:0]       PWDATA,
  output logic [DATA_W-1:0]       PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  input  logic [NIN*DATA_W-1:0]   INREG,
  output logic [NREGS*DATA_W-1:0] REGS_OUT,
  output logic [NREGS-1:0]        WR_STROBE
);
  localparam logic [ADDR_W-1:0] RW_END = ADDR_W'(NREGS);
  localparam logic [ADDR_W-1:0] IN_END = ADDR_W'(NREGS + NIN);
  localparam logic [3:0] WAIT_C = 4'(WAIT);
  if (NREGS + NIN >= 2 ** ADDR_W) begin : g_map_check
    $error("apb_regfile: NREGS+NIN must be below 2**ADDR_W");
  end
  if (WAIT < 0 || WAIT > 15) begin : g_wait_check
    $error("apb_regfile: WAIT must be in 0..15");
  end
  logic [NREGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [NIN-1:0][DATA_W-1:0]   in_w;
  logic [NREGS-1:0]             strobe_q, strobe_d;
  logic [3:0]                   cnt_q, cnt_d;
  logic [DATA_W-1:0]            rd_q, rd_d, rd_val;
  logic                         err_q, err_d;
  logic                         access, setup, ready, done;
  logic                         is_id, is_rw, is_in;
  assign in_w   = INREG;
  // Gating access with PRESETn keeps the bus outputs at their idle values while reset is held.
  assign access = PRESETn & PSEL & PENABLE;
  assign setup  = PSEL & ~PENABLE;
  assign ready  = ~access | (cnt_q == WAIT_C);
  assign done   = access & ready;
  assign is_id  = &PADDR;
  assign is_rw  = ~is_id & (PADDR < RW_END);
  assign is_in  = ~is_id & (PADDR >= RW_END) & (PADDR < IN_END);
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NREGS; i++) rd_val = (PADDR == ADDR_W'(i)) ? regs_q[i] : rd_val;
    for (int i = 0; i < NIN; i++) rd_val = (PADDR == ADDR_W'(NREGS + i)) ? in_w[i] : rd_val;
    rd_val = is_id ? ID_VALUE : rd_val;
  end
  always_comb begin
    cnt_d = (access & ~ready) ? cnt_q + 4'd1 : '0;
    rd_d  = setup ? rd_val : rd_q;
    err_d = setup ? (~(is_rw | is_in | is_id) | (PWRITE & ~is_rw)) : err_q;
    for (int i = 0; i < NREGS; i++) begin
      strobe_d[i] = done & PWRITE & is_rw & (PADDR == ADDR_W'(i));
      regs_d[i]   = strobe_d[i] ? PWDATA : regs_q[i];
    end
  end
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      regs_q   <= {NREGS{RESET_VAL}};
      strobe_q <= '0;
      cnt_q    <= '0;
      rd_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      strobe_q <= strobe_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      err_q    <= err_d;
    end
  end
  assign PREADY    = ready;
  assign PRDATA    = (done & ~PWRITE) ? rd_q : '0;
  assign PSLVERR   = done & err_q;
  assign REGS_OUT  = regs_q;
  assign WR_STROBE = strobe_q;
endmodule

// File: doc/apb_regfile.md
Name: apb_regfile

Overview:
- Parametrised APB3 slave register file; the next generation of the fixed zero-returning, zero-wait APB slave behind the debugger_apb master.
- Provides NREGS read/write registers, NIN read-only input windows and a constant ID register.
- Adds configurable wait states, PSLVERR on unmapped addresses and per-register write strobes.
- Sits on the PCLK/PRESETn APB bus driven by the debugger.

Parameters:
- ADDR_W, 5: PADDR width.
- DATA_W, 8: PWDATA/PRDATA width.
- NREGS, 8: number of RW registers, at addresses 0..NREGS-1.
- NIN, 1: number of read-only input words, at addresses NREGS..NREGS+NIN-1.
- WAIT, 0: wait states per access, range 0..15.
- RESET_VAL, 0: reset value of every RW register (DATA_W bits).
- ID_VALUE, 8'hA5: constant returned at address 2^ADDR_W-1.

Ports:
- PCLK  in  1  clock; all state updates on rising edge.
- PRESETn  in  1  reset; asynchronous assert, active-low.
- PSEL  in  1  APB select.
- PADDR  in  ADDR_W  APB address.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  1=write, 0=read.
- PWDATA  in  DATA_W  write data.
- PRDATA  out  DATA_W  read data.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  error response, valid when PREADY=1 in the access phase.
- INREG  in  NIN*DATA_W  read-only inputs; word k is at bits [k*DATA_W +: DATA_W].
- REGS_OUT  out  NREGS*DATA_W  current RW register contents, same packing as INREG.
- WR_STROBE  out  NREGS  one-cycle pulse per register written.

Behaviour:
- Reset (PRESETn=0, asynchronous):
  - Registers = RESET_VAL, wait counter = 0, read latch = 0.
  - WR_STROBE = 0, PRDATA = 0, PSLVERR = 0, PREADY = 1.
- Address decode:
  - RW: addr < NREGS.
  - IN: NREGS <= addr < NREGS+NIN.
  - ID: addr = 2^ADDR_W-1; ID overrides a RW/IN overlap.
  - All other addresses are invalid.
  - NREGS+NIN must be < 2^ADDR_W; generate-time error otherwise.
- Phases:
  - Setup = PSEL & ~PENABLE.
  - Access = PSEL & PENABLE.
- Setup edge:
  - rd_q <= decoded read value: register, INREG word or ID_VALUE; 0 if invalid.
  - err_q <= invalid.
  - INREG is sampled here and not re-sampled during waits.
- Wait counter cnt (4 bits):
  - Increments each access cycle while cnt != WAIT.
  - Clears on completion and whenever not in access.
- PREADY = ~access | (cnt == WAIT). With WAIT=0 the access phase completes in its first cycle, i.e. the transfer takes 2 PCLK cycles total.
- Completion = access & PREADY.
- Write commit:
  - At the completion edge with PWRITE=1 and a RW address: reg[addr] <= PWDATA, and WR_STROBE[addr] = 1 for exactly the following cycle.
  - Writes to IN, ID or invalid addresses change nothing and produce no strobe.
- PRDATA = rd_q when access & ~PWRITE & PREADY, else 0.
- PSLVERR = err_q when access & PREADY, else 0.
  - Writes to IN/ID addresses also return PSLVERR=1 (err_q is set for any non-RW write at setup).
- Back-to-back transfers:
  - A new setup may follow completion directly.
  - A read of a register written by the previous transfer returns the new value, because the setup edge follows the commit edge.
- Abort: PSEL falling during waits clears cnt, with no write and no strobe.
- Parameter changes and PADDR changes during access (protocol violation): behaviour is undefined except that registers never change without completion.
- Reset mid-wait: reset wins immediately. No commit occurs, and the next access starts from cnt=0.

Test Plan:
1. Reset, WAIT=0: write 8'h3C to addr 2 -> PREADY=1 in the first access cycle, WR_STROBE=8'b0000_0100 for one cycle, REGS_OUT word 2=8'h3C; read addr 2 -> PRDATA=8'h3C, PSLVERR=0.
2. WAIT=3: read addr 0 -> PREADY low for 3 access cycles, then high with PRDATA=RESET_VAL; total transfer takes 5 cycles.
3. INREG=8'h5A: read addr 8 -> 8'h5A; read addr 31 -> 8'hA5; write 8'hFF to addr 8 -> PSLVERR=1, no strobe, a subsequent read of addr 8 still returns 8'h5A.
4. Read addr 12 (unmapped) -> PRDATA=0, PSLVERR=1; write addr 12 -> PSLVERR=1, all REGS_OUT unchanged.
5. WAIT=2: write 8'h11 to addr 1, drop PSEL after 1 wait cycle -> REGS_OUT word 1 unchanged, no strobe; a following full write completes normally after 2 waits.
6. Write 8'h77 to addr 7, then assert PRESETn=0 mid-wait with WAIT=4 -> outputs go immediately to reset values, word 7 = RESET_VAL, no strobe.
